// File: rtl/minterm_sweep_ctrl_pkg.sv
// Shared definitions for the minterm sweep controller: FSM encoding, value
// widths and a small one-hot helper.
package minterm_sweep_ctrl_pkg;

  localparam int VAL_W    = 4;
  localparam int NUM_VALS = 16;
  localparam int CNT_W    = 5;

  localparam logic [VAL_W-1:0] VAL_ONE = {{(VAL_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // One-hot mask bit for a scanned value.
  function automatic logic [NUM_VALS-1:0] valToBit(input logic [VAL_W-1:0] v);
    return {{(NUM_VALS-1){1'b0}}, 1'b1} << v;
  endfunction

endpackage

// File: rtl/minterm_sweep_ctrl_if.sv
// Control, hit-stream and result signals of the sweep controller, with
// modports for the controller (slave) and the system driving it (master).
interface minterm_sweep_ctrl_if;
  import minterm_sweep_ctrl_pkg::*;

  logic                start;
  logic [VAL_W-1:0]    lo;
  logic [VAL_W-1:0]    hi;
  logic                busy;
  logic                hit_valid;
  logic [VAL_W-1:0]    hit_data;
  logic                hit_ready;
  logic [NUM_VALS-1:0] hit_mask;
  logic [CNT_W-1:0]    hit_count;
  logic                done;

  modport master (
    output start, lo, hi, hit_ready,
    input  busy, hit_valid, hit_data, hit_mask, hit_count, done
  );

  modport slave (
    input  start, lo, hi, hit_ready,
    output busy, hit_valid, hit_data, hit_mask, hit_count, done
  );

endinterface

// File: rtl/function4x1.sv
// Combinational 4-input function under test; true for minterms
// {2, 3, 5, 7, 11, 13} of {a,b,c,d} with a as MSB.
module function4x1 (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic f
);

  assign f = (~a & ~b &  c)
           | (~a &  b &  d)
           | ( a & ~b &  c & d)
           | ( a &  b & ~c & d);

endmodule

// File: rtl/minterm_sweep_top.sv
// Integration wrapper: sweep controller wired straight into function4x1.
module minterm_sweep_top (
  input  logic                clk,
  input  logic                rst,
  minterm_sweep_ctrl_if.slave bus
);

  logic w_a;
  logic w_b;
  logic w_c;
  logic w_d;
  logic w_f;

  minterm_sweep_ctrl u_ctrl (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .a   (w_a),
    .b   (w_b),
    .c   (w_c),
    .d   (w_d),
    .f   (w_f)
  );

  function4x1 u_fn (
    .a (w_a),
    .b (w_b),
    .c (w_c),
    .d (w_d),
    .f (w_f)
  );

endmodule

// File: rtl/minterm_sweep_ctrl.sv
// Walks a 4-bit value over [lo..hi] (wrapping), drives it into the function
// block, and records/streams every value for which f is true.
module minterm_sweep_ctrl
  import minterm_sweep_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  minterm_sweep_ctrl_if.slave  bus,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  output logic                 d,
  input  logic                 f
);

  state_t              r_state;
  state_t              w_stateNext;
  logic [VAL_W-1:0]    r_cur;
  logic [VAL_W-1:0]    w_curNext;
  logic [VAL_W-1:0]    r_hi;
  logic [VAL_W-1:0]    w_hiNext;
  logic [VAL_W-1:0]    r_hitData;
  logic [VAL_W-1:0]    w_hitDataNext;
  logic                r_hitValid;
  logic                w_hitValidNext;
  logic [NUM_VALS-1:0] r_mask;
  logic [NUM_VALS-1:0] w_maskNext;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_countNext;
  logic                w_atEnd;

  assign w_atEnd = (r_cur == r_hi);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cur      <= '0;
      r_hi       <= '0;
      r_hitData  <= '0;
      r_hitValid <= 1'b0;
      r_mask     <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_cur      <= w_curNext;
      r_hi       <= w_hiNext;
      r_hitData  <= w_hitDataNext;
      r_hitValid <= w_hitValidNext;
      r_mask     <= w_maskNext;
      r_count    <= w_countNext;
    end
  end

  // Everything holds by default, so an EMIT stall freezes cur, mask and count.
  always_comb begin
    w_stateNext    = r_state;
    w_curNext      = r_cur;
    w_hiNext       = r_hi;
    w_hitDataNext  = r_hitData;
    w_hitValidNext = r_hitValid;
    w_maskNext     = r_mask;
    w_countNext    = r_count;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_curNext   = bus.lo;
          w_hiNext    = bus.hi;
          w_maskNext  = '0;
          w_countNext = '0;
          w_stateNext = SCAN;
        end
      end

      SCAN: begin
        if (f) begin
          w_maskNext     = r_mask | valToBit(r_cur);
          w_countNext    = r_count + CNT_ONE;
          w_hitDataNext  = r_cur;
          w_hitValidNext = 1'b1;
          w_stateNext    = EMIT;
        end else if (w_atEnd) begin
          w_stateNext = DONE;
        end else begin
          w_curNext = r_cur + VAL_ONE;
        end
      end

      EMIT: begin
        if (bus.hit_ready) begin
          w_hitValidNext = 1'b0;
          if (w_atEnd) begin
            w_stateNext = DONE;
          end else begin
            w_curNext   = r_cur + VAL_ONE;
            w_stateNext = SCAN;
          end
        end
      end

      DONE: begin
        w_stateNext = IDLE;
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign {a, b, c, d}  = r_cur;
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == DONE);
  assign bus.hit_valid = r_hitValid;
  assign bus.hit_data  = r_hitData;
  assign bus.hit_mask  = r_mask;
  assign bus.hit_count = r_count;

endmodule

// File: tb/tb_minterm_sweep_ctrl.sv
// Directed bench for minterm_sweep_ctrl against function4x1, with the
// integration wrapper run in lockstep on the same stimulus.
module tb_minterm_sweep_ctrl;
  import minterm_sweep_ctrl_pkg::*;

  logic clk;
  logic rst;
  logic a, b, c, d, f;
  int   numCompared;
  int   numMismatched;

  localparam logic [63:0] FULL_HITS = 64'h0000_0000_00DB_7532;
  localparam logic [63:0] WRAP_HITS = 64'h0000_0000_0000_032D;
  localparam logic [63:0] SEVEN_HIT = 64'h0000_0000_0000_0007;

  minterm_sweep_ctrl_if bus ();
  minterm_sweep_ctrl_if busW ();

  minterm_sweep_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .f   (f)
  );

  function4x1 fn (
    .a (a),
    .b (b),
    .c (c),
    .d (d),
    .f (f)
  );

  minterm_sweep_top wrap (
    .clk (clk),
    .rst (rst),
    .bus (busW)
  );

  assign busW.start     = bus.start;
  assign busW.lo        = bus.lo;
  assign busW.hi        = bus.hi;
  assign busW.hit_ready = bus.hit_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numCompared++;
    if (obs !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one sweep from IDLE; cycle 0 is the cycle start is held high.
  task automatic applyStimulus(input string name, input logic [3:0] loV, input logic [3:0] hiV,
                               input int stall, input logic [63:0] hitList, input int expNum,
                               input logic [15:0] expMask, input int expDoneCyc, input int midStart);
    int   idx;
    int   stallCnt;
    logic sawDone;
    logic [3:0] expHit;
    idx      = 0;
    stallCnt = 0;
    sawDone  = 1'b0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.lo        = loV;
    bus.hi        = hiV;
    bus.hit_ready = 1'b1;
    for (int cyc = 1; cyc <= 200 && !sawDone; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == midStart);
      if (cyc == midStart) begin
        bus.lo = 4'd9;
        bus.hi = 4'd9;
      end
      if (cyc == 1) begin
        checkOutput({name, ":busyFirstScan"}, {31'd0, bus.busy}, 32'd1);
        checkOutput({name, ":abcdFirstScan"}, {28'd0, a, b, c, d}, {28'd0, loV});
      end
      if (bus.hit_valid) begin
        if (idx < expNum) begin
          expHit = hitList[4*idx +: 4];
          checkOutput({name, ":hitData"}, {28'd0, bus.hit_data}, {28'd0, expHit});
          checkOutput({name, ":abcdInEmit"}, {28'd0, a, b, c, d}, {28'd0, expHit});
          if (stallCnt < stall) begin
            bus.hit_ready = 1'b0;
            stallCnt++;
          end else begin
            bus.hit_ready = 1'b1;
            checkOutput({name, ":wrapHitValid"}, {31'd0, busW.hit_valid}, 32'd1);
            checkOutput({name, ":wrapHitData"}, {28'd0, busW.hit_data}, {28'd0, expHit});
            idx++;
          end
        end else begin
          checkOutput({name, ":extraHit"}, idx + 1, expNum);
          bus.hit_ready = 1'b1;
          idx++;
        end
      end else begin
        stallCnt      = 0;
        bus.hit_ready = 1'b1;
      end
      if (bus.done) begin
        sawDone = 1'b1;
        checkOutput({name, ":doneCycle"}, cyc, expDoneCyc);
        checkOutput({name, ":hitMask"}, {16'd0, bus.hit_mask}, {16'd0, expMask});
        checkOutput({name, ":hitCount"}, {27'd0, bus.hit_count}, expNum);
        checkOutput({name, ":busyInDone"}, {31'd0, bus.busy}, 32'd1);
        checkOutput({name, ":hitsStreamed"}, idx, expNum);
        checkOutput({name, ":wrapDone"}, {31'd0, busW.done}, 32'd1);
        checkOutput({name, ":wrapMask"}, {16'd0, busW.hit_mask}, {16'd0, expMask});
        checkOutput({name, ":wrapCount"}, {27'd0, busW.hit_count}, expNum);
      end
    end
    checkOutput({name, ":doneSeen"}, {31'd0, sawDone}, 32'd1);
    @(negedge clk);
    checkOutput({name, ":busyIdle"}, {31'd0, bus.busy}, 32'd0);
    checkOutput({name, ":donePulse"}, {31'd0, bus.done}, 32'd0);
    checkOutput({name, ":maskHeld"}, {16'd0, bus.hit_mask}, {16'd0, expMask});
  endtask

  initial begin
    logic found;
    numCompared   = 0;
    numMismatched = 0;
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.lo        = 4'd0;
    bus.hi        = 4'd0;
    bus.hit_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    checkOutput("reset:abcd", {28'd0, a, b, c, d}, 32'd0);
    checkOutput("reset:hitValid", {31'd0, bus.hit_valid}, 32'd0);
    checkOutput("reset:hitData", {28'd0, bus.hit_data}, 32'd0);
    checkOutput("reset:hitMask", {16'd0, bus.hit_mask}, 32'd0);
    checkOutput("reset:hitCount", {27'd0, bus.hit_count}, 32'd0);
    checkOutput("reset:busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset:done", {31'd0, bus.done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus("full",   4'd0,  4'd15, 0, FULL_HITS, 6, 16'h28AC, 23, 0);
    applyStimulus("wrap",   4'd12, 4'd3,  0, WRAP_HITS, 3, 16'h200C, 12, 0);
    applyStimulus("single4",4'd4,  4'd4,  0, 64'd0,     0, 16'h0000, 2,  0);
    applyStimulus("single7",4'd7,  4'd7,  0, SEVEN_HIT, 1, 16'h0080, 3,  0);
    applyStimulus("stall",  4'd0,  4'd15, 3, FULL_HITS, 6, 16'h28AC, 41, 0);
    applyStimulus("midStart",4'd0, 4'd15, 0, FULL_HITS, 6, 16'h28AC, 23, 5);

    // Start a sweep and hold off the consumer once hit 5 is presented.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.lo        = 4'd0;
    bus.hi        = 4'd15;
    bus.hit_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    found     = 1'b0;
    for (int cyc = 0; cyc < 100 && !found; cyc++) begin
      if (bus.hit_valid && bus.hit_data == 4'd5) begin
        found         = 1'b1;
        bus.hit_ready = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    checkOutput("rst:foundHit5", {31'd0, found}, 32'd1);
    checkOutput("rst:countBefore", {27'd0, bus.hit_count}, 32'd3);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst:hitValid", {31'd0, bus.hit_valid}, 32'd0);
    checkOutput("rst:hitData", {28'd0, bus.hit_data}, 32'd0);
    checkOutput("rst:hitMask", {16'd0, bus.hit_mask}, 32'd0);
    checkOutput("rst:hitCount", {27'd0, bus.hit_count}, 32'd0);
    checkOutput("rst:busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst:done", {31'd0, bus.done}, 32'd0);
    checkOutput("rst:abcd", {28'd0, a, b, c, d}, 32'd0);
    checkOutput("rst:wrapHitValid", {31'd0, busW.hit_valid}, 32'd0);
    @(negedge clk);
    rst           = 1'b0;
    bus.hit_ready = 1'b1;
    checkOutput("rst:noDoneAfter", {31'd0, bus.done}, 32'd0);
    applyStimulus("afterRst", 4'd0, 4'd15, 0, FULL_HITS, 6, 16'h28AC, 23, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
